// File: rtl/icap_multiboot_ctrl.sv
// Spartan-6 MultiBoot reboot sequencer: arbitrates host/watchdog reboot requests
// and streams the IPROG command words into ICAP through a registered, bit-reversed stage.
module icap_multiboot_ctrl #(
  parameter int unsigned STARTUP_CYCLES = 16,
  parameter logic [23:0] IMAGE_STRIDE   = 24'h054000,
  parameter logic [2:0]  GOLDEN_SLOT    = 3'd0,
  parameter logic [7:0]  SPI_RD_OP      = 8'h03
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_host,
  input  logic [2:0]  slot_host,
  input  logic        req_wdt,
  output logic        busy,
  output logic        done,
  output logic        grant_wdt,
  output logic        icap_ce_n,
  output logic        icap_wr_n,
  output logic [15:0] icap_i
);

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_SEQ,
    ST_DONE
  } state_t;

  localparam logic [15:0] STARTUP_LAST = 16'(STARTUP_CYCLES - 1);
  localparam logic [3:0]  LAST_WORD    = 4'd12;

  state_t      state, state_nxt;
  logic [15:0] startup_cnt, startup_cnt_nxt;
  logic [3:0]  word_idx, word_idx_nxt;
  logic        pend_host, pend_host_nxt;
  logic        pend_wdt, pend_wdt_nxt;
  logic [2:0]  slot_lat, slot_lat_nxt;
  logic [2:0]  slot_sel, slot_sel_nxt;
  logic        wdt_won, wdt_won_nxt;
  logic [23:0] flash_addr;
  logic [15:0] seq_word;
  logic        seq_active;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = b[7-k];
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_STARTUP;
      startup_cnt <= '0;
      word_idx    <= '0;
      pend_host   <= 1'b0;
      pend_wdt    <= 1'b0;
      slot_lat    <= '0;
      slot_sel    <= '0;
      wdt_won     <= 1'b0;
    end else begin
      state       <= state_nxt;
      startup_cnt <= startup_cnt_nxt;
      word_idx    <= word_idx_nxt;
      pend_host   <= pend_host_nxt;
      pend_wdt    <= pend_wdt_nxt;
      slot_lat    <= slot_lat_nxt;
      slot_sel    <= slot_sel_nxt;
      wdt_won     <= wdt_won_nxt;
    end
  end

  // Request latching happens first so that a grant in the same cycle clears any
  // pulse arriving alongside it; once sequencing starts, pulses are ignored.
  always_comb begin
    state_nxt       = state;
    startup_cnt_nxt = startup_cnt;
    word_idx_nxt    = word_idx;
    pend_host_nxt   = pend_host;
    pend_wdt_nxt    = pend_wdt;
    slot_lat_nxt    = slot_lat;
    slot_sel_nxt    = slot_sel;
    wdt_won_nxt     = wdt_won;

    if (state == ST_STARTUP || state == ST_IDLE) begin
      if (req_host) begin
        pend_host_nxt = 1'b1;
        slot_lat_nxt  = slot_host;
      end
      if (req_wdt) pend_wdt_nxt = 1'b1;
    end

    case (state)
      ST_STARTUP: begin
        if (startup_cnt == STARTUP_LAST) begin
          startup_cnt_nxt = '0;
          state_nxt       = ST_IDLE;
        end else begin
          startup_cnt_nxt = startup_cnt + 16'd1;
        end
      end
      ST_IDLE: begin
        if (pend_wdt || pend_host) begin
          slot_sel_nxt  = pend_wdt ? GOLDEN_SLOT : slot_lat;
          wdt_won_nxt   = pend_wdt;
          pend_host_nxt = 1'b0;
          pend_wdt_nxt  = 1'b0;
          word_idx_nxt  = '0;
          state_nxt     = ST_SEQ;
        end
      end
      ST_SEQ: begin
        if (word_idx == LAST_WORD) state_nxt = ST_DONE;
        else word_idx_nxt = word_idx + 4'd1;
      end
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_STARTUP;
    endcase
  end

  assign flash_addr = IMAGE_STRIDE * {21'd0, slot_sel};

  // IPROG sequence: sync, set GENERAL_1/2 to the slot's flash address, then IPROG.
  always_comb begin
    seq_word = 16'h2000;
    case (word_idx)
      4'd0:    seq_word = 16'hAA99;
      4'd1:    seq_word = 16'h5566;
      4'd2:    seq_word = 16'h3261;
      4'd3:    seq_word = flash_addr[15:0];
      4'd4:    seq_word = 16'h3281;
      4'd5:    seq_word = {SPI_RD_OP, flash_addr[23:16]};
      4'd6:    seq_word = 16'h30A1;
      4'd7:    seq_word = 16'h000E;
      default: seq_word = 16'h2000;
    endcase
  end

  assign seq_active = (state == ST_SEQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      icap_ce_n <= 1'b1;
      icap_wr_n <= 1'b1;
      icap_i    <= 16'hFFFF;
    end else begin
      icap_ce_n <= ~seq_active;
      icap_wr_n <= ~seq_active;
      icap_i    <= seq_active ? {bitrev8(seq_word[15:8]), bitrev8(seq_word[7:0])} : 16'hFFFF;
    end
  end

  assign busy      = (state == ST_SEQ) || (state == ST_DONE);
  assign done      = (state == ST_DONE);
  assign grant_wdt = busy && wdt_won;

endmodule

// File: tb/tb_icap_multiboot_ctrl.sv
// Self-checking bench for icap_multiboot_ctrl: table of directed reboot scenarios
// plus randomized requests checked against a slot-arithmetic reference model.
module tb_icap_multiboot_ctrl;

  localparam int STARTUP = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_host = 1'b0;
  logic [2:0]  slot_host = 3'd0;
  logic        req_wdt = 1'b0;
  logic        busy, done, grant_wdt, icap_ce_n, icap_wr_n;
  logic [15:0] icap_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit         do_host;
    logic [2:0] slot;
    bit         do_wdt;
    bit         late;
    bit         second;
    logic [2:0] slot2;
    logic [15:0] gen1;
    logic [15:0] gen2;
    bit         exp_wdt;
    bit         mid_reset;
    bit         seq_pulses;
  } vec_t;

  vec_t vecs[11];

  icap_multiboot_ctrl #(
    .STARTUP_CYCLES(STARTUP),
    .IMAGE_STRIDE(24'h054000),
    .GOLDEN_SLOT(3'd0),
    .SPI_RD_OP(8'h03)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_host(req_host),
    .slot_host(slot_host),
    .req_wdt(req_wdt),
    .busy(busy),
    .done(done),
    .grant_wdt(grant_wdt),
    .icap_ce_n(icap_ce_n),
    .icap_wr_n(icap_wr_n),
    .icap_i(icap_i)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] bitrev16(input logic [15:0] w);
    logic [15:0] r;
    for (int k = 0; k < 8; k++) begin
      r[k]     = w[7-k];
      r[8 + k] = w[15-k];
    end
    return r;
  endfunction

  // Reference: the IPROG word list with the flash address derived as slot*stride mod 2^24.
  function automatic logic [15:0] model_word(input int idx, input int slot);
    int addr;
    addr = (slot * 344064) % 16777216;
    case (idx)
      0: return 16'hAA99;
      1: return 16'h5566;
      2: return 16'h3261;
      3: return 16'(addr % 65536);
      4: return 16'h3281;
      5: return 16'(32'h0300 + addr / 65536);
      6: return 16'h30A1;
      7: return 16'h000E;
      default: return 16'h2000;
    endcase
  endfunction

  function automatic vec_t mk(input bit h, input int s, input bit w, input bit late, input bit sec,
                              input int s2, input logic [15:0] g1, input logic [15:0] g2,
                              input bit ew, input bit mr, input bit sp);
    vec_t v;
    v.do_host = h; v.slot = 3'(s); v.do_wdt = w; v.late = late; v.second = sec; v.slot2 = 3'(s2);
    v.gen1 = g1; v.gen2 = g2; v.exp_wdt = ew; v.mid_reset = mr; v.seq_pulses = sp;
    return v;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    req_host = 1'b0;
    req_wdt = 1'b0;
    tick();
    tick();
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_done", {31'd0, done}, 32'd0);
    check_output("rst_grant_wdt", {31'd0, grant_wdt}, 32'd0);
    check_output("rst_pins", {15'd0, icap_ce_n, icap_wr_n, icap_i}, {15'd0, 2'b11, 16'hFFFF});
    reset = 1'b0;
  endtask

  task automatic apply_stimulus(input string name, input vec_t v);
    logic [15:0] exp_w[13];
    logic [15:0] got[20];
    logic [15:0] raw[20];
    int t, req_tick, strobe_tick, hi, n, late_strobes;
    bit wr_ok, busy_ok;

    for (int i = 0; i < 13; i++) exp_w[i] = model_word(i, 0);
    exp_w[3] = v.gen1;
    exp_w[5] = v.gen2;

    apply_reset();
    req_tick = v.late ? STARTUP + 4 : 3;
    t = 0;
    strobe_tick = -1;
    while (t < 80 && strobe_tick < 0) begin
      if (t == req_tick) begin
        req_host = v.do_host;
        slot_host = v.slot;
        req_wdt = v.do_wdt;
      end
      if (v.second && t == req_tick + 2) begin
        req_host = 1'b1;
        slot_host = v.slot2;
      end
      tick();
      t++;
      req_host = 1'b0;
      req_wdt = 1'b0;
      if (icap_ce_n == 1'b0) strobe_tick = t;
    end
    check_output({name, "_strobe_seen"}, {31'd0, strobe_tick >= 0}, 32'd1);
    if (strobe_tick < 0) return;
    hi = ((req_tick + 1 > STARTUP) ? req_tick + 1 : STARTUP) + 2;
    check_output({name, "_strobe_window"}, {31'd0, (strobe_tick >= STARTUP) && (strobe_tick <= hi)}, 32'd1);

    n = 0;
    wr_ok = 1'b1;
    busy_ok = 1'b1;
    check_output({name, "_grant_wdt"}, {31'd0, grant_wdt}, {31'd0, v.exp_wdt});
    while (icap_ce_n == 1'b0 && n < 20) begin
      got[n] = bitrev16(icap_i);
      raw[n] = icap_i;
      wr_ok &= (icap_wr_n == 1'b0);
      busy_ok &= (busy == 1'b1);
      n++;
      if (v.mid_reset && n == 7) break;
      if (v.seq_pulses && n == 5) begin
        req_host = 1'b1;
        slot_host = 3'd7;
        req_wdt = 1'b1;
      end
      tick();
      req_host = 1'b0;
      req_wdt = 1'b0;
    end
    check_output({name, "_wr_strobe"}, {31'd0, wr_ok}, 32'd1);
    check_output({name, "_busy_seq"}, {31'd0, busy_ok}, 32'd1);

    if (v.mid_reset) begin
      check_output({name, "_words_before_reset"}, n, 7);
      reset = 1'b1;
      #1;
      check_output({name, "_async_pins"}, {15'd0, icap_ce_n, icap_wr_n, icap_i}, {15'd0, 2'b11, 16'hFFFF});
      check_output({name, "_async_done_busy"}, {30'd0, done, busy}, 32'd0);
      tick();
      tick();
      reset = 1'b0;
      late_strobes = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (icap_ce_n == 1'b0 || icap_wr_n == 1'b0) late_strobes++;
      end
      check_output({name, "_no_restart"}, late_strobes, 0);
      return;
    end

    check_output({name, "_word_count"}, n, 13);
    for (int i = 0; i < 13 && i < n; i++)
      check_output($sformatf("%s_word%0d", name, i), {16'd0, got[i]}, {16'd0, exp_w[i]});
    if (n >= 2) begin
      check_output({name, "_raw0"}, {16'd0, raw[0]}, 32'h5599);
      check_output({name, "_raw1"}, {16'd0, raw[1]}, 32'hAA66);
    end
    check_output({name, "_after_last"}, {13'd0, done, busy, icap_ce_n, icap_wr_n, icap_i},
                 {13'd0, 4'b1111, 16'hFFFF});
    late_strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (icap_ce_n == 1'b0 || done != 1'b1 || busy != 1'b1) late_strobes++;
    end
    check_output({name, "_done_hold"}, late_strobes, 0);
  endtask

  initial begin
    int slot, slot2, mode, eff;
    bit use_wdt;
    vec_t v;

    vecs[0]  = mk(1, 1, 0, 0, 0, 0, 16'h4000, 16'h0305, 0, 0, 1);
    vecs[1]  = mk(1, 2, 0, 0, 0, 0, 16'h8000, 16'h030A, 0, 0, 0);
    vecs[2]  = mk(1, 3, 0, 1, 0, 0, 16'hC000, 16'h030F, 0, 0, 0);
    vecs[3]  = mk(1, 4, 0, 1, 0, 0, 16'h0000, 16'h0315, 0, 0, 0);
    vecs[4]  = mk(1, 5, 0, 0, 0, 0, 16'h4000, 16'h031A, 0, 0, 0);
    vecs[5]  = mk(1, 6, 0, 0, 0, 0, 16'h8000, 16'h031F, 0, 0, 1);
    vecs[6]  = mk(1, 7, 0, 1, 0, 0, 16'hC000, 16'h0324, 0, 0, 0);
    vecs[7]  = mk(1, 5, 1, 1, 0, 0, 16'h0000, 16'h0300, 1, 0, 0);
    vecs[8]  = mk(0, 0, 1, 0, 0, 0, 16'h0000, 16'h0300, 1, 0, 0);
    vecs[9]  = mk(1, 2, 0, 0, 1, 6, 16'h8000, 16'h031F, 0, 0, 0);
    vecs[10] = mk(1, 3, 0, 0, 0, 0, 16'hC000, 16'h030F, 0, 1, 0);

    for (int i = 0; i < 11; i++) apply_stimulus($sformatf("vec%0d", i), vecs[i]);

    for (int r = 0; r < 12; r++) begin
      slot  = int'($urandom_range(0, 7));
      slot2 = int'($urandom_range(0, 7));
      mode  = int'($urandom_range(0, 3));
      use_wdt = (mode == 1) || (mode == 2);
      eff = use_wdt ? 0 : ((mode == 3) ? slot2 : slot);
      v = mk(mode != 1, slot, use_wdt, (mode != 3) && ($urandom_range(0, 1) == 1), mode == 3, slot2,
             model_word(3, eff), model_word(5, eff), use_wdt, 0, $urandom_range(0, 1) == 1);
      apply_stimulus($sformatf("rnd%0d", r), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
